// File: rtl/rs15_9_syndrome_calc.sv
// RS(15,9) syndrome calculator over GF(16), p(x) = x^4 + x + 1.
// Evaluates the received polynomial at alpha^1..alpha^NUM_SYN with Horner's
// rule, one symbol per clock, highest-order symbol first. The syndromes and
// the error flag are published together with a one-cycle done pulse.
module rs15_9_syndrome_calc #(
  parameter int N_SYM   = 15,
  parameter int NUM_SYN = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [59:0] i_codeword,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic [23:0] o_syndromes,
  output logic        o_error_detected
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // The counter walks from the highest used symbol index down to r0.
  localparam logic [3:0] CNT_INIT = 4'(N_SYM - 1);

  state_t      r_state;
  logic [59:0] r_codeword;
  logic [3:0]  r_cnt;
  logic [23:0] r_acc;

  logic [3:0]  w_sym;
  logic [23:0] w_accNext;

  // GF(16) product: shift-and-add, reducing by x^4 = x + 1 after every shift.
  function automatic logic [3:0] gfMul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] prod;
    logic [3:0] shifted;
    prod    = 4'h0;
    shifted = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        prod = prod ^ shifted;
      end
      shifted = {shifted[2:0], 1'b0} ^ (shifted[3] ? 4'h3 : 4'h0);
    end
    return prod;
  endfunction

  // Evaluation points alpha^1..alpha^6 for syndromes S1..S6.
  function automatic logic [3:0] alphaPow(input int j);
    logic [3:0] val;
    case (j)
      1:       val = 4'h2;
      2:       val = 4'h4;
      3:       val = 4'h8;
      4:       val = 4'h3;
      5:       val = 4'h6;
      6:       val = 4'hC;
      default: val = 4'h0;
    endcase
    return val;
  endfunction

  // One Horner step for every active syndrome; unused slots stay zero.
  always_comb begin
    w_sym     = r_codeword[{r_cnt, 2'b00} +: 4];
    w_accNext = '0;
    for (int j = 0; j < NUM_SYN; j++) begin
      w_accNext[4*j +: 4] = gfMul(r_acc[4*j +: 4], alphaPow(j + 1)) ^ w_sym;
    end
  end

  // Control FSM with registered outputs; results are only updated on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_codeword       <= '0;
      r_cnt            <= '0;
      r_acc            <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_syndromes      <= '0;
      o_error_detected <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_codeword <= i_codeword;
            r_acc      <= '0;
            r_cnt      <= CNT_INIT;
            o_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_accNext;
          if (r_cnt == 4'd0) begin
            o_syndromes      <= w_accNext;
            o_error_detected <= |w_accNext;
            o_done           <= 1'b1;
            o_busy           <= 1'b0;
            r_state          <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          o_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs15_9_syndrome_calc.sv
// Scoreboard bench for rs15_9_syndrome_calc: stimulus pushes hand-computed
// syndromes into a queue, an independent monitor pops and compares on done.
module tb_rs15_9_syndrome_calc;

  logic        clk;
  logic        rst_n;
  logic [59:0] i_codeword;
  logic        i_start;
  logic        o_busy;
  logic        o_done;
  logic [23:0] o_syndromes;
  logic        o_error_detected;

  int checks;
  int errors;
  logic [24:0] expQueue[$];

  rs15_9_syndrome_calc #(
    .N_SYM  (15),
    .NUM_SYN(6)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_codeword      (i_codeword),
    .i_start         (i_start),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_syndromes     (o_syndromes),
    .o_error_detected(o_error_detected)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the stimulus process.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_done && o_busy) begin
        checkOutput("busy_done_exclusive", 64'({o_busy, o_done}), 64'h1);
      end
      if (o_done) begin
        if (expQueue.size() == 0) begin
          checkOutput("unexpected_done", 64'(o_syndromes), 64'hFFFF_FFFF);
        end else begin
          logic [24:0] exp;
          exp = expQueue.pop_front();
          checkOutput("syndromes", 64'(o_syndromes), 64'(exp[23:0]));
          checkOutput("error_detected", 64'(o_error_detected), 64'(exp[24]));
        end
      end
    end
  end

  // Drive a single-cycle start so it is sampled at the next rising edge (E0).
  task automatic startRun(input logic [59:0] cw);
    @(negedge clk);
    i_codeword = cw;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Count busy cycles and the done latency measured in clocks after E0.
  task automatic waitDone(input int alreadyElapsed);
    int busyCycles;
    int doneAt;
    busyCycles = alreadyElapsed;
    doneAt     = -1;
    for (int k = alreadyElapsed + 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_busy) busyCycles++;
      if (o_done) begin
        doneAt = k;
        break;
      end
    end
    checkOutput("done_latency", 64'(doneAt), 64'd16);
    checkOutput("busy_cycles", 64'(busyCycles), 64'd15);
  endtask

  task automatic applyStimulus(input logic [59:0] cw, input logic [23:0] expSyn);
    expQueue.push_back({|expSyn, expSyn});
    startRun(cw);
    waitDone(1);
    @(negedge clk);
  endtask

  initial begin
    int doneCount;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_codeword = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(o_busy), 64'd0);
    checkOutput("reset_done", 64'(o_done), 64'd0);
    checkOutput("reset_syndromes", 64'(o_syndromes), 64'd0);
    checkOutput("reset_error", 64'(o_error_detected), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-derived syndromes.
    applyStimulus(60'h0, 24'h000000);
    applyStimulus(60'h000000001793CAC, 24'h000000);
    applyStimulus(60'h000000000000001, 24'h111111);
    applyStimulus(60'h000000000000010, 24'hC63842);
    applyStimulus(60'h000000000000100, 24'hF75C34);
    checkOutput("hold_syndromes", 64'(o_syndromes), 64'hF75C34);

    // Highest symbol r14; also change codeword mid-run and pulse start during DONE.
    expQueue.push_back({1'b1, 24'hA7EFD9});
    startRun(60'h100000000000000);
    i_codeword = 60'hFFFFFFFFFFFFFFF;
    for (int k = 2; k <= 16; k++) @(negedge clk);
    checkOutput("done_at_16", 64'(o_done), 64'd1);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    checkOutput("start_in_done_ignored", 64'(o_busy), 64'd0);
    @(negedge clk);
    checkOutput("still_idle", 64'(o_busy), 64'd0);
    checkOutput("syndromes_not_cleared", 64'(o_syndromes), 64'hA7EFD9);

    // Second start at cycle 5 of a run must be ignored.
    expQueue.push_back({1'b1, 24'h111111});
    startRun(60'h000000001793CAD);
    repeat (3) @(negedge clk);
    i_codeword = 60'h000000000000010;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    waitDone(5);
    doneCount = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_done) doneCount++;
    end
    checkOutput("single_done", 64'(doneCount), 64'd0);

    // Asynchronous reset mid-run discards everything.
    startRun(60'h1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(o_busy), 64'd0);
    checkOutput("midrst_done", 64'(o_done), 64'd0);
    checkOutput("midrst_syndromes", 64'(o_syndromes), 64'd0);
    checkOutput("midrst_error", 64'(o_error_detected), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_done) doneCount++;
    end
    checkOutput("no_done_after_reset", 64'(doneCount), 64'd0);
    applyStimulus(60'h000000000000010, 24'hC63842);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 64'(expQueue.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
